control_unit: RTL and testbench

- Hardwired Moore-style sequencer for the miniSRC datapath.
- Replaces the hand-driven T-state stimulus: it generates every datapath control strobe from a step counter and the IR opcode.
- Sequence per instruction: fetch (T0–T2), then an opcode-class-specific execute sequence (T3–T7), then back to T0.
- Sits beside miniSRC, with its outputs wired one-to-one to the datapath control inputs.

---
 rtl/control_unit.sv | 180 ++++++++++++++++++
 tb/tb_control_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the miniSRC datapath: a step counter plus IR opcode
// decode drive every datapath control strobe.
module control_unit #(
    parameter logic [4:0] NOP_OP = 5'b11010,
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CONFF_out,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        IncPC,
    output logic        PCin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIout,
    output logic        HIin,
    output logic        LOout,
    output logic        LOin,
    output logic        Cout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        Zin,
    output logic        MDRout,
    output logic        MDRin,
    output logic        MARin,
    output logic        memRead,
    output logic        memWrite,
    output logic        inPortOut,
    output logic        outPort_en,
    output logic        CONin,
    output logic [4:0]  opcode,
    output logic        run
);

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpAnd  = 5'b01010;
    localparam logic [4:0] OpOr   = 5'b01011;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpOri  = 5'b01110;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;
    localparam logic [4:0] OpBr   = 5'b10011;
    localparam logic [4:0] OpJr   = 5'b10100;
    localparam logic [4:0] OpIn   = 5'b10110;
    localparam logic [4:0] OpOut  = 5'b10111;
    localparam logic [4:0] OpMfhi = 5'b11000;
    localparam logic [4:0] OpMflo = 5'b11001;
    localparam logic [4:0] OpHalt = 5'b11011;

    typedef enum logic [3:0] {
        StReset, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_t;

    state_t     state_q, state_d, last_step;
    logic [4:0] op;
    logic       is_ralu, is_ialu, is_unary, is_muldiv, is_ldst, is_single;

    assign op        = IR[31:27];
    assign is_ralu   = (op >= OpAdd) && (op <= OpOr);
    assign is_ialu   = (op >= OpAddi) && (op <= OpOri);
    assign is_unary  = (op == OpNeg) || (op == OpNot);
    assign is_muldiv = (op == OpMul) || (op == OpDiv);
    assign is_ldst   = (op == OpLd) || (op == OpLdi) || (op == OpSt);
    assign is_single = op inside {OpJr, OpIn, OpOut, OpMfhi, OpMflo};

    // Final execute step per opcode class; StT0 means fetch-only (nop, jal, undefined).
    always_comb begin
        last_step = StT0;
        if (is_ralu || is_ialu || op == OpLdi) last_step = StT5;
        else if (is_unary)                     last_step = StT4;
        else if (is_muldiv || op == OpBr)      last_step = StT6;
        else if (op == OpLd || op == OpSt)     last_step = StT7;
        else if (is_single)                    last_step = StT3;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset: state_d = StT0;
            StT0:    state_d = StT1;
            StT1:    state_d = StT2;
            StT2: begin
                if (op == OpHalt)              state_d = StHalt;
                else if (last_step == StT0)    state_d = StT0;
                else                           state_d = StT3;
            end
            StT3, StT4, StT5, StT6, StT7:
                state_d = (state_q >= last_step) ? StT0 : state_t'(state_q + 4'd1);
            StHalt:  state_d = StHalt;
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) state_q <= StReset;
        else        state_q <= state_d;
    end

    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout}                       = '0;
        {PCout, IncPC, PCin, IRin}                              = '0;
        {Yin, HIout, HIin, LOout, LOin, Cout, Zhighout, Zlowout, Zin} = '0;
        {MDRout, MDRin, MARin, memRead, memWrite}               = '0;
        {inPortOut, outPort_en, CONin}                          = '0;
        opcode = NOP_OP;
        run    = 1'b1;
        case (state_q)
            StT0: {PCout, MARin, IncPC, Zin} = '1;
            StT1: {Zlowout, PCin, memRead, MDRin} = '1;
            StT2: {MDRout, IRin} = '1;
            StT3: begin
                if (is_ralu || is_ialu) {Grb, Rout, Yin} = '1;
                else if (is_unary) begin
                    {Grb, Rout, Zin} = '1;
                    opcode = op;
                end
                else if (is_muldiv)     {Gra, Rout, Yin} = '1;
                else if (is_ldst)       {Grb, BAout, Yin} = '1;
                else if (op == OpBr)    {Gra, Rout, CONin} = '1;
                else if (op == OpJr)    {Gra, Rout, PCin} = '1;
                else if (op == OpIn)    {inPortOut, Gra, Rin} = '1;
                else if (op == OpOut)   {Gra, Rout, outPort_en} = '1;
                else if (op == OpMfhi)  {HIout, Gra, Rin} = '1;
                else if (op == OpMflo)  {LOout, Gra, Rin} = '1;
            end
            StT4: begin
                if (is_ralu || is_muldiv) begin
                    if (is_ralu) {Grc, Rout, Zin} = '1;
                    else         {Grb, Rout, Zin} = '1;
                    opcode = op;
                end
                else if (is_ialu) begin
                    {Cout, Zin} = '1;
                    opcode = (op == OpAndi) ? OpAnd : (op == OpOri) ? OpOr : OpAdd;
                end
                else if (is_unary)      {Zlowout, Gra, Rin} = '1;
                else if (is_ldst) begin
                    {Cout, Zin} = '1;
                    opcode = ADD_OP;
                end
                else if (op == OpBr)    {PCout, Yin} = '1;
            end
            StT5: begin
                if (is_ralu || is_ialu || op == OpLdi) {Zlowout, Gra, Rin} = '1;
                else if (is_muldiv)                    {Zlowout, LOin} = '1;
                else if (op == OpLd || op == OpSt)     {Zlowout, MARin} = '1;
                else if (op == OpBr) begin
                    {Cout, Zin} = '1;
                    opcode = ADD_OP;
                end
            end
            StT6: begin
                if (is_muldiv)                  {Zhighout, HIin} = '1;
                else if (op == OpLd)            {memRead, MDRin} = '1;
                else if (op == OpSt)            {Gra, Rout, MDRin} = '1;
                else if (op == OpBr && CONFF_out) {Zlowout, PCin} = '1;
            end
            StT7: begin
                if (op == OpLd)      {MDRout, Gra, Rin} = '1;
                else if (op == OpSt) memWrite = 1'b1;
            end
            StReset, StHalt: run = 1'b0;
            default: run = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expected strobe sequences are
// built from the instruction table and compared cycle by cycle.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] IR;
    logic        CONFF_out;
    logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, IncPC, PCin, IRin;
    logic Yin, HIout, HIin, LOout, LOin, Cout, Zhighout, Zlowout, Zin;
    logic MDRout, MDRin, MARin, memRead, memWrite, inPortOut, outPort_en, CONin;
    logic [4:0] opcode;
    logic       run;

    control_unit dut (
        .clock(clock), .clear(clear), .IR(IR), .CONFF_out(CONFF_out),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .IRin(IRin),
        .Yin(Yin), .HIout(HIout), .HIin(HIin), .LOout(LOout), .LOin(LOin), .Cout(Cout),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .Zin(Zin),
        .MDRout(MDRout), .MDRin(MDRin), .MARin(MARin), .memRead(memRead),
        .memWrite(memWrite), .inPortOut(inPortOut), .outPort_en(outPort_en), .CONin(CONin),
        .opcode(opcode), .run(run)
    );

    always #5 clock = ~clock;

    localparam logic [26:0] GRA = 27'd1 << 0,  GRB = 27'd1 << 1,  GRC = 27'd1 << 2;
    localparam logic [26:0] RIN = 27'd1 << 3,  ROUT = 27'd1 << 4, BAOUT = 27'd1 << 5;
    localparam logic [26:0] PCOUT = 27'd1 << 6, INCPC = 27'd1 << 7, PCIN = 27'd1 << 8;
    localparam logic [26:0] IRIN = 27'd1 << 9, YIN = 27'd1 << 10, HIOUT = 27'd1 << 11;
    localparam logic [26:0] HIIN = 27'd1 << 12, LOOUT = 27'd1 << 13, LOIN = 27'd1 << 14;
    localparam logic [26:0] COUT = 27'd1 << 15, ZHIGHOUT = 27'd1 << 16, ZLOWOUT = 27'd1 << 17;
    localparam logic [26:0] ZIN = 27'd1 << 18, MDROUT = 27'd1 << 19, MDRIN = 27'd1 << 20;
    localparam logic [26:0] MARIN = 27'd1 << 21, MEMREAD = 27'd1 << 22, MEMWRITE = 27'd1 << 23;
    localparam logic [26:0] INPORTOUT = 27'd1 << 24, OUTPORTEN = 27'd1 << 25;
    localparam logic [26:0] CONIN = 27'd1 << 26;
    localparam logic [26:0] BUS = PCOUT | ROUT | BAOUT | ZLOWOUT | ZHIGHOUT | MDROUT |
                                  HIOUT | LOOUT | INPORTOUT | COUT;
    localparam logic [4:0]  NOP = 5'b11010;
    localparam logic [4:0]  ADD = 5'b00011;

    logic [26:0] strobes;
    assign strobes = {CONin, outPort_en, inPortOut, memWrite, memRead, MARin, MDRin, MDRout,
                      Zin, Zlowout, Zhighout, Cout, LOin, LOout, HIin, HIout, Yin, IRin, PCin,
                      IncPC, PCout, BAout, Rout, Rin, Grc, Grb, Gra};

    typedef struct packed {
        logic [26:0] s;
        logic [4:0]  op;
        logic        run;
    } step_t;

    step_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    function automatic void push(input logic [26:0] s, input logic [4:0] op);
        step_t st;
        st.s   = s;
        st.op  = op;
        st.run = 1'b1;
        exp_q.push_back(st);
    endfunction

    // Reference: fetch, then the execute steps listed for the instruction's opcode.
    function automatic void build(input logic [31:0] ir, input logic conff);
        logic [4:0] op;
        op = ir[31:27];
        exp_q.delete();
        push(PCOUT | MARIN | INCPC | ZIN, NOP);
        push(ZLOWOUT | PCIN | MEMREAD | MDRIN, NOP);
        push(MDROUT | IRIN, NOP);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
                push(GRB | ROUT | YIN, NOP);
                push(GRC | ROUT | ZIN, op);
                push(ZLOWOUT | GRA | RIN, NOP);
            end
            5'd12, 5'd13, 5'd14: begin
                push(GRB | ROUT | YIN, NOP);
                push(COUT | ZIN, (op == 5'd12) ? 5'b00011 : (op == 5'd13) ? 5'b01010 : 5'b01011);
                push(ZLOWOUT | GRA | RIN, NOP);
            end
            5'd17, 5'd18: begin
                push(GRB | ROUT | ZIN, op);
                push(ZLOWOUT | GRA | RIN, NOP);
            end
            5'd15, 5'd16: begin
                push(GRA | ROUT | YIN, NOP);
                push(GRB | ROUT | ZIN, op);
                push(ZLOWOUT | LOIN, NOP);
                push(ZHIGHOUT | HIIN, NOP);
            end
            5'd0, 5'd1, 5'd2: begin
                push(GRB | BAOUT | YIN, NOP);
                push(COUT | ZIN, ADD);
                if (op == 5'd1) begin
                    push(ZLOWOUT | GRA | RIN, NOP);
                end else begin
                    push(ZLOWOUT | MARIN, NOP);
                    if (op == 5'd0) begin
                        push(MEMREAD | MDRIN, NOP);
                        push(MDROUT | GRA | RIN, NOP);
                    end else begin
                        push(GRA | ROUT | MDRIN, NOP);
                        push(MEMWRITE, NOP);
                    end
                end
            end
            5'd19: begin
                push(GRA | ROUT | CONIN, NOP);
                push(PCOUT | YIN, NOP);
                push(COUT | ZIN, ADD);
                push(conff ? (ZLOWOUT | PCIN) : 27'd0, NOP);
            end
            5'd20: push(GRA | ROUT | PCIN, NOP);
            5'd22: push(INPORTOUT | GRA | RIN, NOP);
            5'd23: push(GRA | ROUT | OUTPORTEN, NOP);
            5'd24: push(HIOUT | GRA | RIN, NOP);
            5'd25: push(LOOUT | GRA | RIN, NOP);
            default: ;
        endcase
    endfunction

    // Steps one instruction from T0; optionally pulls clear low after step abort_at.
    task automatic do_instr(input logic [31:0] ir, input logic conff, input int abort_at);
        build(ir, conff);
        foreach (exp_q[i]) begin
            @(posedge clock);
            #1;
            vectors++;
            if ({strobes, opcode, run} !== {exp_q[i].s, exp_q[i].op, exp_q[i].run}) begin
                miscompares++;
                $display("FAIL step ir=%h T%0d: got strobes=%h opcode=%b run=%b, want strobes=%h opcode=%b run=%b",
                         ir, i, strobes, opcode, run, exp_q[i].s, exp_q[i].op, exp_q[i].run);
            end
            vectors++;
            if ($countones(strobes & BUS) > 1) begin
                miscompares++;
                $display("FAIL bus_drivers ir=%h T%0d: got drivers=%h, want at most one",
                         ir, i, strobes & BUS);
            end
            if (i == 0) begin
                IR = ir;
                CONFF_out = conff;
            end
            if (i == abort_at) begin
                clear = 1'b0;
                @(posedge clock);
                #1;
                vectors++;
                if ({strobes, opcode, run} !== {27'd0, NOP, 1'b0}) begin
                    miscompares++;
                    $display("FAIL abort_reset ir=%h: got strobes=%h opcode=%b run=%b, want 0 %b 0",
                             ir, strobes, opcode, run, NOP);
                end
                clear = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        clear = 1'b0;
        IR = 32'd0;
        CONFF_out = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
            vectors++;
            if ({strobes, opcode, run} !== {27'd0, NOP, 1'b0}) begin
                miscompares++;
                $display("FAIL reset: got strobes=%h opcode=%b run=%b, want 0 %b 0",
                         strobes, opcode, run, NOP);
            end
        end
        clear = 1'b1;
    endtask

    task automatic test_ld();
        do_instr(32'h01080095, 1'b0, -1);
    endtask

    task automatic test_add();
        do_instr(32'h19890000, 1'b0, -1);
    endtask

    task automatic test_branch();
        do_instr({5'b10011, 4'd2, 23'd0}, 1'b0, -1);
        do_instr({5'b10011, 4'd2, 23'd0}, 1'b1, -1);
    endtask

    task automatic test_store();
        do_instr({5'b00010, 4'd3, 4'd1, 19'h0042}, 1'b0, -1);
        do_instr({5'b00010, 4'd3, 4'd1, 19'h0042}, 1'b0, 6);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 60; n++) begin
            logic [4:0] op;
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b11010;
            do_instr({op, 27'($urandom)}, 1'($urandom), -1);
        end
    endtask

    task automatic test_halt();
        do_instr(32'hD8000000, 1'b0, -1);
        repeat (12) begin
            @(posedge clock);
            #1;
            vectors++;
            if ({strobes, opcode, run} !== {27'd0, NOP, 1'b0}) begin
                miscompares++;
                $display("FAIL halt_hold: got strobes=%h opcode=%b run=%b, want 0 %b 0",
                         strobes, opcode, run, NOP);
            end
        end
        clear = 1'b0;
        @(posedge clock);
        #1;
        vectors++;
        if ({strobes, opcode, run} !== {27'd0, NOP, 1'b0}) begin
            miscompares++;
            $display("FAIL halt_clear: got strobes=%h opcode=%b run=%b, want 0 %b 0",
                     strobes, opcode, run, NOP);
        end
        clear = 1'b1;
        do_instr(32'h19890000, 1'b0, -1);
        do_instr(32'hD0000000, 1'b0, -1);
        do_instr(32'hD0000000, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_ld();
        test_add();
        test_branch();
        test_store();
        test_back_to_back();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
